inert_sequencer: RTL

INERT_SEQUENCER -- requirements
Module: inert_sequencer

---
 rtl/inert_sequencer_if.sv | 10 +
 rtl/inert_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/inert_sequencer_if.sv
// SPI transaction handshake between the inertial sequencer (master) and its SPI transceiver.
interface inert_sequencer_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] inertial_data;

    modport master (output wrt, output cmd, input done, input inertial_data);
    modport slave  (input wrt, input cmd, output done, output inertial_data);
endinterface

// File: rtl/inert_sequencer.sv
// NEMO gyro sequencer: power-on wait, three configuration writes, then interrupt-driven
// two-transaction yaw-rate reads over SPI.
module inert_sequencer #(
    // Power-on wait terminal count; only shortened for quick simulation runs.
    parameter logic [15:0] PwrWait = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              INT,
    inert_sequencer_if.master spi,
    output logic              setup_done,
    output logic [15:0]       yaw,
    output logic              vld,
    output logic              busy
);

    typedef enum logic [2:0] {
        StPwr,
        StCfg1,
        StCfg2,
        StCfg3,
        StWaitInt,
        StRdL,
        StRdH
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic        int_ff1, int_ff2;
    logic [7:0]  low_q, low_d;
    logic        wrt_d;
    logic [15:0] cmd_d;
    logic        setup_done_d;
    logic [15:0] yaw_d;
    logic        vld_d;
    logic        busy_d;

    // Only the low byte of each read-back word carries data.
    logic unused_data_hi;
    assign unused_data_hi = ^spi.inertial_data[15:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_ff1 <= 1'b0;
            int_ff2 <= 1'b0;
        end else begin
            int_ff1 <= INT;
            int_ff2 <= int_ff1;
        end
    end

    assign timer_d = (timer_q == PwrWait) ? timer_q : timer_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        low_d        = low_q;
        wrt_d        = 1'b0;
        cmd_d        = spi.cmd;
        busy_d       = busy;
        setup_done_d = setup_done;
        yaw_d        = yaw;
        vld_d        = 1'b0;
        unique case (state_q)
            StPwr: begin
                if (timer_q == PwrWait) begin
                    state_d = StCfg1;
                    wrt_d   = 1'b1;
                    cmd_d   = 16'h0D02;
                end
            end
            StCfg1: begin
                if (spi.done) begin
                    state_d = StCfg2;
                    wrt_d   = 1'b1;
                    cmd_d   = 16'h1160;
                end
            end
            StCfg2: begin
                if (spi.done) begin
                    state_d = StCfg3;
                    wrt_d   = 1'b1;
                    cmd_d   = 16'h1440;
                end
            end
            StCfg3: begin
                if (spi.done) begin
                    state_d      = StWaitInt;
                    busy_d       = 1'b0;
                    setup_done_d = 1'b1;
                end
            end
            StWaitInt: begin
                if (int_ff2 && setup_done) begin
                    state_d = StRdL;
                    wrt_d   = 1'b1;
                    cmd_d   = 16'hA600;
                end
            end
            StRdL: begin
                if (spi.done) begin
                    low_d   = spi.inertial_data[7:0];
                    state_d = StRdH;
                    wrt_d   = 1'b1;
                    cmd_d   = 16'hA700;
                end
            end
            StRdH: begin
                if (spi.done) begin
                    // Both bytes land in yaw together so it is never half-updated.
                    yaw_d   = {spi.inertial_data[7:0], low_q};
                    vld_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StWaitInt;
                end
            end
            default: state_d = StPwr;
        endcase
        if (wrt_d) busy_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StPwr;
            timer_q    <= 16'h0000;
            low_q      <= 8'h00;
            spi.wrt    <= 1'b0;
            spi.cmd    <= 16'h0000;
            setup_done <= 1'b0;
            yaw        <= 16'h0000;
            vld        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            low_q      <= low_d;
            spi.wrt    <= wrt_d;
            spi.cmd    <= cmd_d;
            setup_done <= setup_done_d;
            yaw        <= yaw_d;
            vld        <= vld_d;
            busy       <= busy_d;
        end
    end

endmodule
